// File: rtl/div_16_8.sv
// rtl/div_16_8.sv - radix-2 restoring 16/8 unsigned divider with valid/ready handshakes
// Optional DIV_BYZERO_DETECT_EN: short-circuit divide-by-zero and raise dbz.
module div_16_8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        dbz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] q_q, q_d;
  logic [7:0]  r_q, r_d;
  logic [7:0]  dv_q, dv_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        r_ge;
  logic [7:0]  r_low;

`ifdef DIV_BYZERO_DETECT_EN
  logic        dbz_q, dbz_d;
`endif

  // The 9-bit trial remainder only matters for the compare; the stored
  // remainder is always below the divisor, so 8-bit modular subtract is exact.
  assign r_ge  = ({r_q, q_q[15]} >= {1'b0, dv_q});
  assign r_low = {r_q[6:0], q_q[15]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      dv_q    <= '0;
      cnt_q   <= '0;
`ifdef DIV_BYZERO_DETECT_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dv_q    <= dv_d;
      cnt_q   <= cnt_d;
`ifdef DIV_BYZERO_DETECT_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    dv_d    = dv_q;
    cnt_d   = cnt_q;
`ifdef DIV_BYZERO_DETECT_EN
    dbz_d   = dbz_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          q_d     = dividend;
          r_d     = '0;
          dv_d    = divisor;
          cnt_d   = '0;
          state_d = CALC;
`ifdef DIV_BYZERO_DETECT_EN
          dbz_d   = 1'b0;
          if (divisor == 8'd0) begin
            q_d     = 16'hFFFF;
            r_d     = dividend[7:0];
            dbz_d   = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        q_d   = {q_q[14:0], r_ge};
        r_d   = r_ge ? (r_low - dv_q) : r_low;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = q_q;
  assign remainder = r_q;

`ifdef DIV_BYZERO_DETECT_EN
  assign dbz = dbz_q;
`else
  assign dbz = 1'b0;
`endif

endmodule

// File: tb/tb_div_16_8.sv
// tb/tb_div_16_8.sv - self-checking bench for div_16_8 against an arithmetic reference
// Honours DIV_BYZERO_DETECT_EN for divide-by-zero latency and dbz expectations.
module tb_div_16_8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        dbz;

  int n_vec = 0;
  int n_err = 0;

  logic        exp_valid = 1'b0;
  logic [15:0] exp_q;
  logic [7:0]  exp_r;
  logic        exp_dbz;

`ifdef DIV_BYZERO_DETECT_EN
  localparam bit DETECT = 1'b1;
`else
  localparam bit DETECT = 1'b0;
`endif

  always #5 clk = ~clk;

  div_16_8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic void model(input logic [15:0] dd, input logic [7:0] dv,
                                output logic [15:0] q, output logic [7:0] r, output logic z);
    if (dv == 8'd0) begin
      q = 16'hFFFF;
      r = dd[7:0];
      z = DETECT;
    end else begin
      q = dd / {8'd0, dv};
      r = 8'(dd % {8'd0, dv});
      z = 1'b0;
    end
  endfunction

  // Whenever a result is presented it must match the pending expectation.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!exp_valid) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        check("quotient", 32'(quotient), 32'(exp_q));
        check("remainder", 32'(remainder), 32'(exp_r));
        check("dbz", 32'(dbz), 32'(exp_dbz));
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_quotient"}, 32'(quotient), 32'd0);
    check({tag, "_remainder"}, 32'(remainder), 32'd0);
    check({tag, "_dbz"}, 32'(dbz), 32'd0);
  endtask

  task automatic do_div(input logic [15:0] dd, input logic [7:0] dv, input int hold);
    logic [15:0] mq;
    logic [7:0]  mr;
    logic        mz;
    int          lat;
    int          lat_exp;
    model(dd, dv, mq, mr, mz);
    lat_exp = (dv == 8'd0 && DETECT) ? 1 : 17;
    @(negedge clk);
    exp_q     = mq;
    exp_r     = mr;
    exp_dbz   = mz;
    exp_valid = 1'b1;
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    dividend  = dd;
    divisor   = dv;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(lat_exp));
    if (dv != 8'd0) begin
      check("equation", 32'(quotient) * 32'(dv) + 32'(remainder), 32'(dd));
      check("rem_lt_div", 32'(remainder < dv), 32'd1);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      dividend = 16'hA5A5;
      divisor  = 8'h11;
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_quotient", 32'(quotient), 32'(mq));
      check("bp_remainder", 32'(remainder), 32'(mr));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("post_hs_out_valid", 32'(out_valid), 32'd0);
    check("post_hs_in_ready", 32'(in_ready), 32'd1);
    exp_valid = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mq;
    logic [7:0]  mr;
    logic        mz;
    bit          seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    model(16'd1000, 8'd7, mq, mr, mz);
    check("model_1000_7_q", 32'(mq), 32'd142);
    check("model_1000_7_r", 32'(mr), 32'd6);
    model(16'hFFFF, 8'hFF, mq, mr, mz);
    check("model_ffff_ff_q", 32'(mq), 32'd257);
    check("model_ffff_ff_r", 32'(mr), 32'd0);
    model(16'd5, 8'd9, mq, mr, mz);
    check("model_5_9_q", 32'(mq), 32'd0);
    check("model_5_9_r", 32'(mr), 32'd5);
    model(16'h1234, 8'd0, mq, mr, mz);
    check("model_div0_q", 32'(mq), 32'hFFFF);
    check("model_div0_r", 32'(mr), 32'h34);
    model(16'd200, 8'd3, mq, mr, mz);
    check("model_200_3_q", 32'(mq), 32'd66);
    check("model_200_3_r", 32'(mr), 32'd2);

    do_div(16'd1000, 8'd7, 0);
    do_div(16'hFFFF, 8'hFF, 0);
    do_div(16'hFFFF, 8'd1, 0);
    do_div(16'd5, 8'd9, 0);
    do_div(16'h1234, 8'd0, 0);
    do_div(16'd40000, 8'd200, 10);
    do_div(16'd12345, 8'd99, 0);

    // Reset mid-calculation discards the in-flight result.
    @(negedge clk);
    exp_valid = 1'b0;
    dividend  = 16'd1000;
    divisor   = 8'd7;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("mid_reset");
    rst  = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("discarded_result", 32'(seen), 32'd0);
    do_div(16'd200, 8'd3, 0);

    for (int k = 0; k < 2000; k++) begin
      do_div(16'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
